// File: rtl/hazard_ctrl_pkg.sv
// Shared CPU definitions for the hazard controller: state encoding and drain defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_ctrl_pkg;

   // Controller state; RUN must encode as 0 so reset lands in RUN.
   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_DRAIN = 1'b1
   } hz_state_e;

   // Default number of hold cycles for a serializing (fence/ecall) instruction.
   localparam int DRAIN_CYCLES_DEF = 3;

   // Drain counter width; covers the legal DRAIN_CYCLES range 1..15.
   localparam int DRAIN_W = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for pipeline performance statistics.
// Latency: count reflects inc one cycle later (registered).
// Backpressure: none; sticks at all-ones instead of wrapping.
//
// Ports: clk, resetn (async active-low), inc (count this cycle), count (current value).
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count_q <= '0;
      end else if (inc && (count_q != {W{1'b1}})) begin
         count_q <= count_q + W'(1);
      end
   end

   assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, serializing-instruction drain, redirect flush.
// Latency: hold/flush outputs are combinational from registered state plus current inputs.
// Backpressure: holds PC and IF/ID and inserts ID/EXE bubbles; redirect overrides all holds.
//
// Ports: clk, resetn; ID sources (id_rs1/2, id_use_rs1/2, id_serialize); EXE info
// (exe_rd, exe_RegWrite, exe_ltype, exe_redirect); control outputs (pc_hold, ifid_hold,
// ifid_flush, idex_flush, idex_pause, busy); perf counters (stall_cnt, flush_cnt).
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic             id_serialize,
   input  logic [4:0]       exe_rd,
   input  logic             exe_RegWrite,
   input  logic             exe_ltype,
   input  logic             exe_redirect,
   output logic             pc_hold,
   output logic             ifid_hold,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             idex_pause,
   output logic             busy,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

   hz_state_e            state_q, state_d;
   logic [DRAIN_W-1:0]   drain_q, drain_d;
   logic                 load_use;
   logic                 hold;
   logic                 flush;

   assign load_use = exe_ltype && exe_RegWrite && (exe_rd != 5'd0) &&
                     ((id_use_rs1 && (id_rs1 == exe_rd)) ||
                      (id_use_rs2 && (id_rs2 == exe_rd)));

   // Priority: redirect > serialize > load-use. Load-use is not looked at while
   // draining because the drain bubbles already cover any outstanding load.
   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      hold    = 1'b0;
      flush   = 1'b0;
      if (exe_redirect) begin
         flush   = 1'b1;
         state_d = ST_RUN;
         drain_d = '0;
      end else if (state_q == ST_RUN) begin
         if (id_serialize) begin
            hold = 1'b1;
            // With a single drain cycle this cycle's hold is the whole drain.
            if (DRAIN_CYCLES > 1) begin
               state_d = ST_DRAIN;
               drain_d = DRAIN_LOAD;
            end
         end else if (load_use) begin
            hold = 1'b1;
         end
      end else begin
         if (drain_q != '0) begin
            hold    = 1'b1;
            drain_d = drain_q - 1'b1;
         end else begin
            // Pipeline is empty: let the serializing instruction issue.
            state_d = ST_RUN;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_RUN;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
      end
   end

   // Outputs are combinational, so gate them explicitly while reset is asserted.
   assign pc_hold    = hold  && resetn;
   assign ifid_hold  = hold  && resetn;
   assign idex_pause = hold  && resetn;
   assign ifid_flush = flush && resetn;
   assign idex_flush = flush && resetn;
   assign busy       = (state_q == ST_DRAIN) && resetn;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk    (clk),
      .resetn (resetn),
      .inc    (idex_pause),
      .count  (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk    (clk),
      .resetn (resetn),
      .inc    (ifid_flush),
      .count  (flush_cnt)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios then random traffic vs a cycle-time model.
// Latency: outputs checked 1 time unit after inputs change, counters checked one cycle later.
// Backpressure: n/a.
module tb_hazard_ctrl;

   localparam int DRAIN = 3;

   logic        clk;
   logic        resetn;
   logic [4:0]  id_rs1, id_rs2, exe_rd;
   logic        id_use_rs1, id_use_rs2, id_serialize;
   logic        exe_RegWrite, exe_ltype, exe_redirect;

   logic        pc_hold, ifid_hold, ifid_flush, idex_flush, idex_pause, busy;
   logic [31:0] stall_cnt, flush_cnt;
   logic        pc_hold4, ifid_hold4, ifid_flush4, idex_flush4, idex_pause4, busy4;
   logic [3:0]  stall_cnt4, flush_cnt4;

   int checks = 0;
   int errors = 0;

   // Model state: cycle index, and the cycle on which a pending serializing
   // instruction is released (-1 when none is pending).
   int     cyc = 0;
   int     rel = -1;
   longint m_stall = 0, m_flush = 0;
   int     m_stall4 = 0, m_flush4 = 0;

   hazard_ctrl #(.DRAIN_CYCLES(DRAIN)) u_dut (
      .clk(clk), .resetn(resetn),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .id_serialize(id_serialize), .exe_rd(exe_rd), .exe_RegWrite(exe_RegWrite),
      .exe_ltype(exe_ltype), .exe_redirect(exe_redirect),
      .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush),
      .idex_flush(idex_flush), .idex_pause(idex_pause), .busy(busy),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(4)) u_dut4 (
      .clk(clk), .resetn(resetn),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .id_serialize(id_serialize), .exe_rd(exe_rd), .exe_RegWrite(exe_RegWrite),
      .exe_ltype(exe_ltype), .exe_redirect(exe_redirect),
      .pc_hold(pc_hold4), .ifid_hold(ifid_hold4), .ifid_flush(ifid_flush4),
      .idex_flush(idex_flush4), .idex_pause(idex_pause4), .busy(busy4),
      .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input logic ser, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic rw, input logic lt, input logic redir);
      id_serialize = ser; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
      exe_rd = rd; exe_RegWrite = rw; exe_ltype = lt; exe_redirect = redir;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "/pc_hold"}, {31'd0, pc_hold}, 32'd0);
      chk({tag, "/ifid_hold"}, {31'd0, ifid_hold}, 32'd0);
      chk({tag, "/idex_pause"}, {31'd0, idex_pause}, 32'd0);
      chk({tag, "/ifid_flush"}, {31'd0, ifid_flush}, 32'd0);
      chk({tag, "/idex_flush"}, {31'd0, idex_flush}, 32'd0);
      chk({tag, "/busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "/stall_cnt"}, stall_cnt, 32'd0);
      chk({tag, "/flush_cnt"}, flush_cnt, 32'd0);
      chk({tag, "/stall_cnt4"}, {28'd0, stall_cnt4}, 32'd0);
   endtask

   task automatic model_reset();
      rel = -1; m_stall = 0; m_flush = 0; m_stall4 = 0; m_flush4 = 0;
   endtask

   // Called at a falling edge with inputs already applied; checks this cycle,
   // advances the model across the next rising edge, returns at the next falling edge.
   task automatic eval(input string tag);
      bit in_drain, lu, eh, ef;
      in_drain = (rel >= cyc);
      lu = exe_ltype && exe_RegWrite && (exe_rd != 0) &&
           ((id_use_rs1 && id_rs1 == exe_rd) || (id_use_rs2 && id_rs2 == exe_rd));
      eh = 1'b0;
      ef = 1'b0;
      if (exe_redirect)      ef = 1'b1;
      else if (in_drain)     eh = (cyc < rel);
      else if (id_serialize) begin eh = 1'b1; rel = cyc + DRAIN; end
      else                   eh = lu;
      #1;
      chk({tag, "/pc_hold"}, {31'd0, pc_hold}, {31'd0, eh});
      chk({tag, "/ifid_hold"}, {31'd0, ifid_hold}, {31'd0, eh});
      chk({tag, "/idex_pause"}, {31'd0, idex_pause}, {31'd0, eh});
      chk({tag, "/ifid_flush"}, {31'd0, ifid_flush}, {31'd0, ef});
      chk({tag, "/idex_flush"}, {31'd0, idex_flush}, {31'd0, ef});
      chk({tag, "/busy"}, {31'd0, busy}, {31'd0, in_drain});
      chk({tag, "/stall_cnt"}, stall_cnt, m_stall[31:0]);
      chk({tag, "/flush_cnt"}, flush_cnt, m_flush[31:0]);
      chk({tag, "/stall_cnt4"}, {28'd0, stall_cnt4}, 32'(m_stall4));
      chk({tag, "/flush_cnt4"}, {28'd0, flush_cnt4}, 32'(m_flush4));
      if (eh) begin
         if (m_stall < 64'hFFFF_FFFF) m_stall++;
         if (m_stall4 < 15) m_stall4++;
      end
      if (ef) begin
         if (m_flush < 64'hFFFF_FFFF) m_flush++;
         if (m_flush4 < 15) m_flush4++;
         rel = -1;
      end
      cyc++;
      @(negedge clk);
   endtask

   initial begin
      resetn = 1'b0;
      set_in(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1);
      #1;
      chk_all_zero("reset");
      model_reset();
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      set_in(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

      // Load-use on rs1 gives exactly one bubble.
      set_in(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
      eval("lu");
      set_in(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      eval("lu_after");
      chk("lu_stall_one", stall_cnt, 32'd1);

      // rd=x0 or rs1 unused: no hazard.
      set_in(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
      eval("lu_x0");
      set_in(1'b0, 5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
      eval("lu_nouse");
      chk("lu_stall_unch", stall_cnt, 32'd1);

      // Serialize held: three hold cycles, released on the fourth.
      set_in(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      repeat (4) eval("ser");
      set_in(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      eval("ser_idle");
      chk("ser_stall", stall_cnt, 32'd4);

      // Redirect on the first drain cycle flushes and returns to RUN.
      set_in(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      eval("rd_ser");
      set_in(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      eval("rd_flush");
      set_in(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      eval("rd_after");
      chk("rd_flush_cnt", flush_cnt, 32'd1);

      // Load-use together with redirect: flush only.
      set_in(1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b1);
      eval("lu_redir");

      // Reset in the middle of a drain.
      set_in(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      eval("rst_ser0");
      eval("rst_ser1");
      resetn = 1'b0;
      set_in(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0);
      #1;
      chk_all_zero("rst_mid");
      model_reset();
      @(negedge clk);
      resetn = 1'b1;
      set_in(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      eval("rst_release");
      eval("rst_idle");

      // Saturation of the 4-bit build.
      set_in(1'b0, 5'd0, 5'd9, 1'b0, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0);
      repeat (20) eval("sat");
      chk("sat_stall4", {28'd0, stall_cnt4}, 32'h0000_000F);

      // Random traffic; small register range makes matches frequent.
      for (int i = 0; i < 400; i++) begin
         set_in(($urandom_range(0, 9) == 0),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom),
                ($urandom_range(0, 15) == 0));
         eval("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
